// File: rtl/frame_buffer_scheduler.sv
// Frame buffer scheduler: owns the single-port frame buffer SRAM and walks each frame
// through clear, rasterizer draw and transfer readout, muxing the SRAM port per phase.
module frame_buffer_scheduler #(
    parameter int WIDTH   = 320,
    parameter int HEIGHT  = 240,
    parameter int ADDR_W  = 17,
    parameter int COLOR_W = 24
) (
    input  logic               i_clk,
    input  logic               i_n_rst,
    input  logic               i_frame_start,
    input  logic [COLOR_W-1:0] i_clear_color,
    input  logic               i_rast_req,
    input  logic [ADDR_W-1:0]  i_rast_addr,
    input  logic [COLOR_W-1:0] i_rast_color,
    output logic               o_rast_gnt,
    input  logic               i_draw_done,
    output logic               o_xfer_start,
    input  logic [ADDR_W-1:0]  i_xfer_addr,
    input  logic               i_xfer_done,
    output logic [ADDR_W-1:0]  o_fb_addr,
    output logic [COLOR_W-1:0] o_fb_wdata,
    output logic               o_fb_we,
    output logic               o_fb_re,
    output logic               o_busy,
    output logic [1:0]         o_phase,
    output logic               o_frame_done,
    output logic [15:0]        o_frame_count,
    output logic               o_oob_err
);

    localparam int                PIXELS    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(PIXELS - 1);
    localparam logic [ADDR_W:0]   PIX_LIMIT = (ADDR_W + 1)'(PIXELS);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DRAW,
        XSTART,
        XFER,
        DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [ADDR_W-1:0]  r_clr_cnt;
    logic [COLOR_W-1:0] r_color;
    logic [15:0]        r_frame_count;
    logic               r_oob_err;
    logic               w_in_range;

    // Extra top bit so a frame filling the whole address space still compares correctly.
    assign w_in_range = ({1'b0, i_rast_addr} < PIX_LIMIT);

    always_ff @(posedge i_clk) begin
        if (i_n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_frame_start) w_next_state = CLEAR;
            CLEAR:   if (r_clr_cnt == LAST_PIX) w_next_state = DRAW;
            DRAW:    if (i_draw_done) w_next_state = XSTART;
            XSTART:  w_next_state = XFER;
            XFER:    if (i_xfer_done) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // SRAM port and handshakes are forced quiet while reset is asserted, whatever the state.
    always_comb begin
        o_fb_addr    = '0;
        o_fb_wdata   = '0;
        o_fb_we      = 1'b0;
        o_fb_re      = 1'b0;
        o_rast_gnt   = 1'b0;
        o_xfer_start = 1'b0;
        o_frame_done = 1'b0;
        if (!i_n_rst) begin
            case (r_state)
                CLEAR: begin
                    o_fb_we    = 1'b1;
                    o_fb_addr  = r_clr_cnt;
                    o_fb_wdata = r_color;
                end
                DRAW: begin
                    o_rast_gnt = i_rast_req;
                    o_fb_addr  = i_rast_addr;
                    o_fb_wdata = i_rast_color;
                    o_fb_we    = i_rast_req && w_in_range;
                end
                XSTART:  o_xfer_start = 1'b1;
                XFER: begin
                    o_fb_re   = 1'b1;
                    o_fb_addr = i_xfer_addr;
                end
                DONE:    o_frame_done = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (r_state)
            CLEAR:         o_phase = 2'd1;
            DRAW:          o_phase = 2'd2;
            XSTART, XFER:  o_phase = 2'd3;
            default:       o_phase = 2'd0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_n_rst) begin
            r_clr_cnt     <= '0;
            r_color       <= '0;
            r_frame_count <= '0;
            r_oob_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_frame_start) begin
                        r_clr_cnt <= '0;
                        r_color   <= i_clear_color;
                    end
                end
                CLEAR:   r_clr_cnt <= r_clr_cnt + 1'b1;
                DRAW:    if (i_rast_req && !w_in_range) r_oob_err <= 1'b1;
                DONE:    r_frame_count <= r_frame_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign o_busy        = (r_state != IDLE);
    assign o_frame_count = r_frame_count;
    assign o_oob_err     = r_oob_err;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed bench for frame_buffer_scheduler on a 4x2 frame: clear, draw, out-of-range
// writes, transfer readout, ignored control pulses and reset in the middle of a clear.
module tb_frame_buffer_scheduler;

    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 2;
    localparam int ADDR_W  = 4;
    localparam int COLOR_W = 24;

    logic               i_clk = 1'b0;
    logic               i_n_rst;
    logic               i_frame_start;
    logic [COLOR_W-1:0] i_clear_color;
    logic               i_rast_req;
    logic [ADDR_W-1:0]  i_rast_addr;
    logic [COLOR_W-1:0] i_rast_color;
    logic               o_rast_gnt;
    logic               i_draw_done;
    logic               o_xfer_start;
    logic [ADDR_W-1:0]  i_xfer_addr;
    logic               i_xfer_done;
    logic [ADDR_W-1:0]  o_fb_addr;
    logic [COLOR_W-1:0] o_fb_wdata;
    logic               o_fb_we;
    logic               o_fb_re;
    logic               o_busy;
    logic [1:0]         o_phase;
    logic               o_frame_done;
    logic [15:0]        o_frame_count;
    logic               o_oob_err;

    int checks = 0;
    int errors = 0;

    frame_buffer_scheduler #(
        .WIDTH   (WIDTH),
        .HEIGHT  (HEIGHT),
        .ADDR_W  (ADDR_W),
        .COLOR_W (COLOR_W)
    ) dut (
        .i_clk         (i_clk),
        .i_n_rst       (i_n_rst),
        .i_frame_start (i_frame_start),
        .i_clear_color (i_clear_color),
        .i_rast_req    (i_rast_req),
        .i_rast_addr   (i_rast_addr),
        .i_rast_color  (i_rast_color),
        .o_rast_gnt    (o_rast_gnt),
        .i_draw_done   (i_draw_done),
        .o_xfer_start  (o_xfer_start),
        .i_xfer_addr   (i_xfer_addr),
        .i_xfer_done   (i_xfer_done),
        .o_fb_addr     (o_fb_addr),
        .o_fb_wdata    (o_fb_wdata),
        .o_fb_we       (o_fb_we),
        .o_fb_re       (o_fb_re),
        .o_busy        (o_busy),
        .o_phase       (o_phase),
        .o_frame_done  (o_frame_done),
        .o_frame_count (o_frame_count),
        .o_oob_err     (o_oob_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow after another unit.
    task automatic applyStimulus();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_n_rst       = 1'b1;
        i_frame_start = 1'b0;
        i_clear_color = '0;
        i_rast_req    = 1'b0;
        i_rast_addr   = '0;
        i_rast_color  = '0;
        i_draw_done   = 1'b0;
        i_xfer_addr   = '0;
        i_xfer_done   = 1'b0;
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_phase", 32'(o_phase), 32'd0);
        checkOutput("rst_we", 32'(o_fb_we), 32'd0);
        checkOutput("rst_count", 32'(o_frame_count), 32'd0);
        checkOutput("rst_oob", 32'(o_oob_err), 32'd0);
        i_n_rst = 1'b0;
        applyStimulus();

        // Frame 1: clear with 123456, rasterizer noise and a stray frame_start during clear
        i_frame_start = 1'b1;
        i_clear_color = 24'h123456;
        #1;
        checkOutput("idle_we", 32'(o_fb_we), 32'd0);
        checkOutput("idle_gnt", 32'(o_rast_gnt), 32'd0);
        applyStimulus();
        i_frame_start = 1'b0;
        i_clear_color = 24'h000000;
        i_rast_req    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_frame_start = (i == 3);
            #1;
            checkOutput("clr_we", 32'(o_fb_we), 32'd1);
            checkOutput("clr_addr", 32'(o_fb_addr), 32'(i));
            checkOutput("clr_data", 32'(o_fb_wdata), 32'h123456);
            checkOutput("clr_gnt", 32'(o_rast_gnt), 32'd0);
            checkOutput("clr_phase", 32'(o_phase), 32'd1);
            applyStimulus();
        end
        i_frame_start = 1'b0;
        i_rast_req    = 1'b0;
        i_xfer_done   = 1'b1;
        #1;
        checkOutput("draw_phase", 32'(o_phase), 32'd2);
        checkOutput("draw_idle_we", 32'(o_fb_we), 32'd0);
        applyStimulus();
        i_xfer_done = 1'b0;
        #1;
        checkOutput("draw_xdone_ign", 32'(o_phase), 32'd2);

        i_rast_req   = 1'b1;
        i_rast_addr  = 4'd9;
        i_rast_color = 24'h0000FF;
        #1;
        checkOutput("oob_gnt", 32'(o_rast_gnt), 32'd1);
        checkOutput("oob_we", 32'(o_fb_we), 32'd0);
        applyStimulus();
        i_rast_req = 1'b0;
        #1;
        checkOutput("oob_err", 32'(o_oob_err), 32'd1);
        applyStimulus();

        i_rast_req   = 1'b1;
        i_rast_addr  = 4'd3;
        i_rast_color = 24'hFF0000;
        #1;
        checkOutput("draw1_gnt", 32'(o_rast_gnt), 32'd1);
        checkOutput("draw1_we", 32'(o_fb_we), 32'd1);
        checkOutput("draw1_addr", 32'(o_fb_addr), 32'd3);
        checkOutput("draw1_data", 32'(o_fb_wdata), 32'hFF0000);
        applyStimulus();
        i_rast_addr  = 4'd5;
        i_rast_color = 24'h00FF00;
        i_draw_done  = 1'b1;
        #1;
        checkOutput("draw2_gnt", 32'(o_rast_gnt), 32'd1);
        checkOutput("draw2_we", 32'(o_fb_we), 32'd1);
        checkOutput("draw2_addr", 32'(o_fb_addr), 32'd5);
        checkOutput("draw2_data", 32'(o_fb_wdata), 32'h00FF00);
        applyStimulus();
        i_rast_req  = 1'b0;
        i_draw_done = 1'b0;
        #1;
        checkOutput("xs_pulse", 32'(o_xfer_start), 32'd1);
        checkOutput("xs_phase", 32'(o_phase), 32'd3);
        checkOutput("xs_we", 32'(o_fb_we), 32'd0);
        checkOutput("xs_re", 32'(o_fb_re), 32'd0);
        applyStimulus();

        i_rast_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_xfer_addr   = 4'(i);
            i_frame_start = (i == 2);
            #1;
            checkOutput("xf_start_once", 32'(o_xfer_start), 32'd0);
            checkOutput("xf_re", 32'(o_fb_re), 32'd1);
            checkOutput("xf_addr", 32'(o_fb_addr), 32'(i));
            checkOutput("xf_we", 32'(o_fb_we), 32'd0);
            checkOutput("xf_gnt", 32'(o_rast_gnt), 32'd0);
            checkOutput("xf_phase", 32'(o_phase), 32'd3);
            applyStimulus();
        end
        i_frame_start = 1'b0;
        i_rast_req    = 1'b0;
        i_xfer_done   = 1'b1;
        #1;
        checkOutput("xf_last_re", 32'(o_fb_re), 32'd1);
        applyStimulus();
        i_xfer_done = 1'b0;
        #1;
        checkOutput("done_pulse", 32'(o_frame_done), 32'd1);
        checkOutput("done_count_pre", 32'(o_frame_count), 32'd0);
        checkOutput("done_phase", 32'(o_phase), 32'd0);
        checkOutput("done_busy", 32'(o_busy), 32'd1);
        applyStimulus();
        #1;
        checkOutput("post_done", 32'(o_frame_done), 32'd0);
        checkOutput("post_count", 32'(o_frame_count), 32'd1);
        checkOutput("post_busy", 32'(o_busy), 32'd0);
        checkOutput("post_oob", 32'(o_oob_err), 32'd1);
        applyStimulus();
        applyStimulus();
        #1;
        checkOutput("no_queue_busy", 32'(o_busy), 32'd0);

        // Frame 2: reset while the clear counter sits at 4
        i_frame_start = 1'b1;
        i_clear_color = 24'hABCDEF;
        applyStimulus();
        i_frame_start = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        #1;
        checkOutput("mid_addr", 32'(o_fb_addr), 32'd4);
        checkOutput("mid_oob", 32'(o_oob_err), 32'd1);
        i_n_rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", 32'(o_fb_we), 32'd0);
        applyStimulus();
        i_n_rst = 1'b0;
        #1;
        checkOutput("mid_phase", 32'(o_phase), 32'd0);
        checkOutput("mid_busy", 32'(o_busy), 32'd0);
        checkOutput("mid_we", 32'(o_fb_we), 32'd0);
        checkOutput("mid_xs", 32'(o_xfer_start), 32'd0);
        checkOutput("mid_count", 32'(o_frame_count), 32'd0);
        checkOutput("mid_oob_clr", 32'(o_oob_err), 32'd0);

        i_frame_start = 1'b1;
        i_clear_color = 24'h0000AA;
        applyStimulus();
        i_frame_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput("re_clr_we", 32'(o_fb_we), 32'd1);
            checkOutput("re_clr_addr", 32'(o_fb_addr), 32'(i));
            checkOutput("re_clr_data", 32'(o_fb_wdata), 32'h0000AA);
            applyStimulus();
        end
        #1;
        checkOutput("re_draw_phase", 32'(o_phase), 32'd2);
        checkOutput("re_draw_we", 32'(o_fb_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
Owns the single-port frame buffer SRAM and sequences each frame through three phases: clear, rasterizer draw, and transfer readout to AHB.
- Clear: an internal counter fills every pixel with a latched clear colour.
- Draw: the rasterizer writes through a req/gnt port.
- Transfer: the port is handed to the frame buffer transfer block, which is started and then awaited.
- Sits between the rasterizer, the frame buffer SRAM and the transfer block.

Parameters:
WIDTH, 320, frame width in pixels
HEIGHT, 240, frame height in pixels
ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT
COLOR_W, 24, pixel colour width

Ports:
clk  in  1  clock
n_rst  in  1  synchronous, active-high reset (1 = reset)
frame_start  in  1  begin a frame; honoured only in IDLE
clear_color  in  COLOR_W  background colour, latched on an accepted frame_start
rast_req  in  1  rasterizer write request
rast_addr  in  ADDR_W  rasterizer pixel address
rast_color  in  COLOR_W  rasterizer pixel colour
rast_gnt  out  1  write accepted this cycle
draw_done  in  1  rasterizer has finished the frame
xfer_start  out  1  one-cycle start pulse to the transfer block
xfer_addr  in  ADDR_W  transfer block read address
xfer_done  in  1  transfer block finished
fb_addr  out  ADDR_W  SRAM address
fb_wdata  out  COLOR_W  SRAM write data
fb_we  out  1  SRAM write enable
fb_re  out  1  SRAM read enable
busy  out  1  state != IDLE
phase  out  2  0 = idle/done, 1 = clear, 2 = draw, 3 = transfer
frame_done  out  1  one-cycle pulse at end of frame
frame_count  out  16  completed frames, wraps at 65535 -> 0
oob_err  out  1  sticky: a rasterizer write was dropped for being out of range

Behaviour:
- Definition: PIXELS = WIDTH*HEIGHT.
- Reset (n_rst=1 at a clk edge): state IDLE, clr_cnt 0, latched colour 0, frame_count 0, oob_err 0.
- While in IDLE, and during reset, all fb_*, rast_gnt, xfer_start and frame_done are 0.
- Reset mid-frame: IDLE on the next edge; no further writes; xfer_start is not reissued.
- Moore decode from state and registered counters; rast_gnt and the fb_* mux are combinational.
- IDLE: frame_start=1 -> CLEAR, clr_cnt<=0, latch clear_color.
- CLEAR:
  - Every cycle: fb_we=1, fb_addr=clr_cnt, fb_wdata=latched colour, clr_cnt++.
  - When clr_cnt==PIXELS-1: the final write occurs, then -> DRAW.
  - Exactly PIXELS write cycles. rast_gnt=0 throughout.
- DRAW:
  - rast_gnt=rast_req. fb_addr=rast_addr, fb_wdata=rast_color.
  - fb_we=rast_req && rast_addr<PIXELS.
  - rast_req with rast_addr>=PIXELS: still granted (no hang), fb_we=0, oob_err<=1.
  - draw_done=1 -> XSTART. A rast_req in the same cycle is granted and written first.
- XSTART: xfer_start=1 for exactly one cycle; fb idle -> XFER.
- XFER:
  - fb_re=1, fb_addr=xfer_addr, fb_we=0, rast_gnt=0.
  - xfer_done=1 -> DONE.
  - xfer_done is ignored outside XFER.
- DONE: frame_done=1 for one cycle; frame_count++ (wrapping); -> IDLE.
- frame_start is ignored outside IDLE; no queuing.
- draw_done outside DRAW is ignored.
- clr_cnt compare is on the full ADDR_W-bit value; no wrap occurs within CLEAR.
- oob_err clears only on reset.
- Frame latency, frame_start to frame_done: 1 + PIXELS + D + 1 + T + 1 cycles.
  - D = cycles spent in DRAW.
  - T = cycles spent in XFER.

Test Plan:
1. WIDTH=4, HEIGHT=2, frame_start with clear_color=24'h123456 -> fb_we=1 for exactly 8 consecutive cycles, addresses 0..7, data 123456, then phase=2; rast_gnt=0 during clear.
2. In DRAW, rast_req with addr=3, color=FF0000, then addr=5, color=00FF00, with draw_done asserted on the second -> both granted and written; xfer_start pulses once on the next cycle; phase=3.
3. In DRAW, rast_req with addr=9 (>=8) -> rast_gnt=1, fb_we=0, oob_err=1 and stays 1 through subsequent frames until reset.
4. In XFER, drive xfer_addr 0..7 over 8 cycles, then xfer_done -> fb_re=1 with fb_addr tracking xfer_addr; one frame_done pulse; frame_count 0->1; busy=0 afterwards.
5. frame_start pulsed during CLEAR and XFER -> ignored: clear count unchanged, only one frame runs; xfer_done pulsed during DRAW -> no state change.
6. n_rst=1 mid-CLEAR at clr_cnt=4 -> next cycle state IDLE, fb_we=0, frame_count=0, and no xfer_start; a following frame_start performs a full 8-cycle clear from addr 0.
